oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite DMA engine on the CPU-side bus, directly upstream of the memory decoder.
- Normally passes CPU core bus cycles through unchanged.
- On a CPU write to 16'h4014, halts the core and copies 256 bytes from CPU page {data,8'h00} into sprite RAM via repeated writes to 16'h2004.
- The decoder's sprite address auto-increment places the bytes.

Parameters:
- RD_LAT, 1, cycles the source address is held after the read strobe before data is captured; legal 1..3.
- START_DLY, 1, dummy halt cycles between trigger and first read; legal 0..3.

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous reset, active-high
- core_addr  in  16  CPU core address
- core_data_wr  in  8  CPU core write data
- core_write_en  in  1  CPU core write strobe
- core_read_en  in  1  CPU core read strobe
- core_data_rd  out  8  read data returned to core
- core_halt  out  1  freeze request to core; high while DMA active
- bus_addr  out  16  to decoder cpu_addr
- bus_data_wr  out  8  to decoder cpu_data_in
- bus_write_en  out  1  to decoder cpu_write_en
- bus_read_en  out  1  to decoder cpu_read_en
- bus_data_rd  in  8  from decoder cpu_data_out
- dma_busy  out  1  status, equals core_halt

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, core_halt=0, dma_busy=0, page=0, byte counter=0, data latch=0, delay counter=0.
- Registered outputs: core_halt and dma_busy.
- bus_* outputs: combinational from state, or pass-through.
- core_data_rd: always equals bus_data_rd.

IDLE:
- bus_addr, bus_data_wr, bus_write_en and bus_read_en equal the core_* inputs.
- Trigger: core_write_en=1 and core_addr=16'h4014. That cycle bus_write_en is forced to 0, so the write is not forwarded.
- At the trigger edge: page<=core_data_wr, counter<=0.
- Next state is DELAY if START_DLY>0, else READ.
- core_halt rises in the cycle after the trigger.

DELAY:
- Lasts START_DLY cycles.
- All bus strobes are 0; bus_addr=0.

READ (1 cycle):
- bus_addr={page,counter}, bus_read_en=1, bus_write_en=0.

WAIT (RD_LAT cycles):
- bus_addr is held at {page,counter}; strobes are 0.
- On the last WAIT cycle's edge, latch<=bus_data_rd.

WRITE (1 cycle):
- bus_addr=16'h2004, bus_data_wr=latch, bus_write_en=1, bus_read_en=0.
- If counter==8'hFF, next state is IDLE. Otherwise counter<=counter+1 and next state is READ.
- The counter is 8-bit and wraps, but the transfer terminates at 8'hFF, so exactly 256 writes occur.

Timing:
- Per byte: 2+RD_LAT cycles.
- Total core_halt high time: START_DLY + 256*(2+RD_LAT) cycles. Defaults give 769.
- core_halt falls in the cycle after the final WRITE. Pass-through resumes in that same cycle.

Boundary conditions:
- Core strobes while busy: ignored, not forwarded. The core is required to be frozen, but the block does not rely on it.
- 16'h4014 written while busy: ignored; page is unchanged and there is no restart.
- Page 8'hFF: source addresses are 16'hFF00..16'hFFFF. Nothing wraps into page 8'h00.
- Page 8'h20: source addresses are register mirrors, read as any other address.
- Reset asserted mid-transfer: next edge gives IDLE, halt 0, no further bus strobes. Partial sprite RAM contents are left as written.
- Trigger coincident with rst: rst wins; stay IDLE.
- Back-to-back trigger on the first IDLE cycle after completion: accepted normally.

Decomposition:
- Shared package nes_bus_pkg holds:
  - constants OAMDMA_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004;
  - state encoding IDLE, DELAY, READ, WAIT, WRITE, 3-bit;
  - the bus width constants ADDR_W=16 and DATA_W=8.
- No sub-module. A single FSM with an 8-bit byte counter and a 2-bit delay/wait counter is the whole block.

Test Plan:
1. Pass-through: in IDLE, core reads 16'h0123 and writes 8'h5A to 16'h2003 -> identical bus_* values the same cycle; core_data_rd equals bus_data_rd; core_halt=0.
2. Full transfer: preload source memory with CPU[16'h0200+i]=i^8'hA5, then core writes 8'h02 to 16'h4014 -> bus write_en not asserted on the trigger cycle. Check:
   - halt high for exactly 769 cycles;
   - 256 writes to 16'h2004 with data i^8'hA5 in order;
   - reads at 16'h0200..16'h02FF;
   - sprite RAM read back via 16'h2004 matches.
3. Parameters: RD_LAT=2, START_DLY=0 -> first READ the cycle after the trigger; 4 cycles per byte; 1024 halt cycles total.
4. Busy interference: mid-transfer at byte 8'h40, drive a core write of 8'h07 to 16'h4014 and a core read of 16'h0000 -> no forwarding; transfer still completes from page 8'h02; 256 writes total.
5. Reset mid-operation: assert rst for 1 cycle at byte 8'h80 -> next cycle IDLE, halt=0, no bus strobes. A new trigger with page 8'h03 then runs a full 256-byte transfer from 16'h0300.
6. Page 8'hFF: last READ address is 16'hFFFF, then halt drops. A trigger on the first post-completion cycle starts a new transfer.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the sprite-DMA state encoding.
package nes_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        READ,
        WAIT,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: passes CPU bus cycles through, and on a write to 4014
// halts the core and copies one 256-byte page to 2004.
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int START_DLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data_wr,
    input  logic              core_write_en,
    input  logic              core_read_en,
    output logic [DATA_W-1:0] core_data_rd,
    output logic              core_halt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_wr,
    output logic              bus_write_en,
    output logic              bus_read_en,
    input  logic [DATA_W-1:0] bus_data_rd,
    output logic              dma_busy
);

    localparam logic [1:0] DLY_LAST  = (START_DLY > 0) ? 2'(START_DLY - 1) : 2'd0;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    dma_state_t        state, state_n;
    logic [7:0]        page, page_n;
    logic [7:0]        cnt, cnt_n;
    logic [1:0]        dcnt, dcnt_n;
    logic [DATA_W-1:0] data_latch, data_latch_n;
    logic              halt;
    logic              trigger;

    assign trigger      = core_write_en && (core_addr == OAMDMA_ADDR);
    assign core_data_rd = bus_data_rd;
    assign core_halt    = halt;
    assign dma_busy     = halt;

    always_comb begin
        state_n      = state;
        page_n       = page;
        cnt_n        = cnt;
        dcnt_n       = dcnt;
        data_latch_n = data_latch;
        bus_addr     = '0;
        bus_data_wr  = '0;
        bus_write_en = 1'b0;
        bus_read_en  = 1'b0;

        case (state)
            IDLE: begin
                bus_addr     = core_addr;
                bus_data_wr  = core_data_wr;
                bus_write_en = core_write_en && !trigger;
                bus_read_en  = core_read_en;
                if (trigger) begin
                    page_n  = core_data_wr;
                    cnt_n   = '0;
                    dcnt_n  = '0;
                    state_n = (START_DLY > 0) ? DELAY : READ;
                end
            end
            DELAY: begin
                if (dcnt == DLY_LAST) begin
                    dcnt_n  = '0;
                    state_n = READ;
                end else begin
                    dcnt_n = dcnt + 2'd1;
                end
            end
            READ: begin
                bus_addr    = {page, cnt};
                bus_read_en = 1'b1;
                dcnt_n      = '0;
                state_n     = WAIT;
            end
            WAIT: begin
                // Address held so the decoder's read data stays valid until capture.
                bus_addr = {page, cnt};
                if (dcnt == WAIT_LAST) begin
                    data_latch_n = bus_data_rd;
                    state_n      = WRITE;
                end else begin
                    dcnt_n = dcnt + 2'd1;
                end
            end
            WRITE: begin
                bus_addr     = OAMDATA_ADDR;
                bus_data_wr  = data_latch;
                bus_write_en = 1'b1;
                if (cnt == 8'hFF) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = cnt + 8'd1;
                    state_n = READ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            page       <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            data_latch <= '0;
            halt       <= 1'b0;
        end else begin
            state      <= state_n;
            page       <= page_n;
            cnt        <= cnt_n;
            dcnt       <= dcnt_n;
            data_latch <= data_latch_n;
            halt       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: CPU memory / sprite RAM model, pass-through table,
// and directed multi-cycle DMA sequences on two parameterisations.
module tb_oam_dma_ctrl;
    import nes_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] core_addr;
    logic [7:0]  core_data_wr;
    logic        core_write_en, core_read_en;
    logic [7:0]  core_data_rd;
    logic        core_halt, dma_busy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_wr, bus_data_rd;
    logic        bus_write_en, bus_read_en;

    logic [15:0] c1_addr;
    logic [7:0]  c1_wdata, c1_rd;
    logic        c1_we, c1_re;
    logic        halt1, busy1;
    logic [15:0] baddr1;
    logic [7:0]  bwd1, brd1;
    logic        bwe1, bre1;

    oam_dma_ctrl dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_data_wr(core_data_wr),
        .core_write_en(core_write_en), .core_read_en(core_read_en),
        .core_data_rd(core_data_rd), .core_halt(core_halt),
        .bus_addr(bus_addr), .bus_data_wr(bus_data_wr),
        .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
        .bus_data_rd(bus_data_rd), .dma_busy(dma_busy)
    );

    oam_dma_ctrl #(.RD_LAT(2), .START_DLY(0)) dut1 (
        .clk(clk), .rst(rst),
        .core_addr(c1_addr), .core_data_wr(c1_wdata),
        .core_write_en(c1_we), .core_read_en(c1_re),
        .core_data_rd(c1_rd), .core_halt(halt1),
        .bus_addr(baddr1), .bus_data_wr(bwd1),
        .bus_write_en(bwe1), .bus_read_en(bre1),
        .bus_data_rd(brd1), .dma_busy(busy1)
    );

    // Decoder model: CPU memory plus sprite RAM behind 2003/2004
    logic [7:0] cpu_mem [65536];
    logic [7:0] oam [256];
    logic [7:0] oam_addr;

    assign bus_data_rd = (bus_addr == OAMDATA_ADDR) ? oam[oam_addr] : cpu_mem[bus_addr];
    assign brd1        = cpu_mem[baddr1];

    always @(posedge clk) begin
        if (bus_write_en) begin
            if (bus_addr == 16'h2003) oam_addr <= bus_data_wr;
            else if (bus_addr == OAMDATA_ADDR) begin
                oam[oam_addr] <= bus_data_wr;
                oam_addr      <= oam_addr + 8'd1;
            end
        end
    end

    logic [7:0]  wr_log [4096];
    logic [15:0] rd_log [4096];
    logic [7:0]  wr1_log [1024];
    int wr_n = 0, rd_n = 0, halt_n = 0;
    int wr1_n = 0, halt1_n = 0;

    always @(posedge clk) begin
        if (core_halt) halt_n <= halt_n + 1;
        if (core_halt && bus_write_en && bus_addr == OAMDATA_ADDR) begin
            wr_log[wr_n] <= bus_data_wr;
            wr_n         <= wr_n + 1;
        end
        if (core_halt && bus_read_en) begin
            rd_log[rd_n] <= bus_addr;
            rd_n         <= rd_n + 1;
        end
        if (halt1) halt1_n <= halt1_n + 1;
        if (halt1 && bwe1 && baddr1 == OAMDATA_ADDR) begin
            wr1_log[wr1_n] <= bwd1;
            wr1_n          <= wr1_n + 1;
        end
    end

    int checks = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic core(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
        core_addr = a; core_data_wr = d; core_write_en = we; core_read_en = re;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (dma_busy && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_done"}, dma_busy, 0);
    endtask

    task automatic wait_read(input string name, input logic [15:0] a);
        int n = 0;
        while (!(bus_read_en && bus_addr == a) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_reached"}, bus_addr, a);
    endtask

    task automatic start_dma(input logic [7:0] page);
        @(negedge clk); core(16'h2003, 8'h00, 1'b1, 1'b0);
        @(negedge clk); core(OAMDMA_ADDR, page, 1'b1, 1'b0);
        #1 chk("trig_not_fwd", bus_write_en, 0);
        @(negedge clk); core(16'h0000, 8'h00, 1'b0, 1'b0);
        #1 chk("halt_rise", core_halt, 1);
    endtask

    task automatic check_xfer(input string name, input int w0, input int r0, input int h0,
                              input logic [7:0] page, input logic [7:0] key);
        logic [7:0] b;
        chk({name, "_halt_cycles"}, halt_n - h0, 769);
        chk({name, "_writes"}, wr_n - w0, 256);
        chk({name, "_reads"}, rd_n - r0, 256);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            chk($sformatf("%s_wr[%0d]", name, i), wr_log[w0 + i], b ^ key);
            chk($sformatf("%s_rd[%0d]", name, i), rd_log[r0 + i], {page, b});
        end
    endtask

    task automatic readback(input string name, input logic [7:0] key);
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            @(negedge clk); core(16'h2003, b, 1'b1, 1'b0);
            @(negedge clk); core(OAMDATA_ADDR, 8'h00, 1'b0, 1'b1);
            #1 chk($sformatf("%s_oam[%0d]", name, i), core_data_rd, b ^ key);
        end
        @(negedge clk); core(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we, re;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        logic        exp_we, exp_re;
        logic [7:0]  exp_rd;
    } pvec_t;

    pvec_t pt [5];
    int w0, r0, h0;
    logic [7:0] b;

    initial begin
        pt[0] = '{16'h0123, 8'h00, 1'b0, 1'b1, 16'h0123, 8'h00, 1'b0, 1'b1, 8'h22};
        pt[1] = '{16'h2003, 8'h5A, 1'b1, 1'b0, 16'h2003, 8'h5A, 1'b1, 1'b0, 8'h23};
        pt[2] = '{16'h0456, 8'hA5, 1'b1, 1'b1, 16'h0456, 8'hA5, 1'b1, 1'b1, 8'h52};
        pt[3] = '{16'h4015, 8'h11, 1'b1, 1'b0, 16'h4015, 8'h11, 1'b1, 1'b0, 8'h55};
        pt[4] = '{16'h4014, 8'h22, 1'b0, 1'b1, 16'h4014, 8'h22, 1'b0, 1'b1, 8'h54};

        for (int a = 0; a < 65536; a++) cpu_mem[a] = 8'(a[7:0] ^ a[15:8]);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            cpu_mem[16'h0200 + i] = b ^ 8'hA5;
            cpu_mem[16'h0300 + i] = b ^ 8'h3C;
            cpu_mem[16'hFF00 + i] = ~b;
        end

        rst = 1'b1;
        core(16'h0000, 8'h00, 1'b0, 1'b0);
        c1_addr = '0; c1_wdata = '0; c1_we = 1'b0; c1_re = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_halt", core_halt, 0);
        chk("rst_busy", dma_busy, 0);
        chk("rst_we", bus_write_en, 0);
        chk("rst_re", bus_read_en, 0);
        chk("rst_halt1", halt1, 0);
        @(negedge clk); rst = 1'b0;

        // Pass-through table
        foreach (pt[k]) begin
            @(negedge clk); core(pt[k].a, pt[k].d, pt[k].we, pt[k].re);
            #1;
            chk($sformatf("pt%0d_addr", k), bus_addr, pt[k].exp_addr);
            chk($sformatf("pt%0d_wd", k), bus_data_wr, pt[k].exp_wd);
            chk($sformatf("pt%0d_we", k), bus_write_en, pt[k].exp_we);
            chk($sformatf("pt%0d_re", k), bus_read_en, pt[k].exp_re);
            chk($sformatf("pt%0d_rd", k), core_data_rd, pt[k].exp_rd);
            chk($sformatf("pt%0d_halt", k), core_halt, 0);
        end
        @(negedge clk); core(16'h0000, 8'h00, 1'b0, 1'b0);

        // Full transfer from page 02
        w0 = wr_n; r0 = rd_n; h0 = halt_n;
        start_dma(8'h02);
        wait_done("t2", 1000);
        check_xfer("t2", w0, r0, h0, 8'h02, 8'hA5);
        readback("t2", 8'hA5);

        // RD_LAT=2, START_DLY=0 instance
        @(negedge clk);
        w0 = wr1_n; h0 = halt1_n;
        c1_addr = OAMDMA_ADDR; c1_wdata = 8'h02; c1_we = 1'b1;
        #1 chk("t3_trig_not_fwd", bwe1, 0);
        @(negedge clk); c1_addr = '0; c1_wdata = '0; c1_we = 1'b0;
        #1;
        chk("t3_first_read", bre1, 1);
        chk("t3_first_addr", baddr1, 16'h0200);
        chk("t3_halt", halt1, 1);
        for (int n = 0; n < 1100 && busy1; n++) begin
            @(negedge clk); #1;
        end
        chk("t3_done", busy1, 0);
        chk("t3_halt_cycles", halt1_n - h0, 1024);
        chk("t3_writes", wr1_n - w0, 256);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            chk($sformatf("t3_wr[%0d]", i), wr1_log[w0 + i], b ^ 8'hA5);
        end

        // Core interference while busy
        w0 = wr_n; r0 = rd_n; h0 = halt_n;
        start_dma(8'h02);
        wait_read("t4", 16'h0240);
        core(OAMDMA_ADDR, 8'h07, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("t4_w_fwd%0d", k), bus_addr == OAMDMA_ADDR, 0);
            @(negedge clk);
        end
        core(16'h0000, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("t4_r_fwd%0d", k), bus_addr == 16'h0000, 0);
            @(negedge clk);
        end
        core(16'h0000, 8'h00, 1'b0, 1'b0);
        #1;
        wait_done("t4", 1000);
        check_xfer("t4", w0, r0, h0, 8'h02, 8'hA5);
        @(negedge clk); #1 chk("t4_no_restart", core_halt, 0);

        // Reset mid-transfer, then a fresh transfer from page 03
        w0 = wr_n;
        start_dma(8'h02);
        wait_read("t5", 16'h0280);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("t5_halt", core_halt, 0);
        chk("t5_busy", dma_busy, 0);
        chk("t5_partial_writes", wr_n - w0, 128);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5_we%0d", k), bus_write_en, 0);
            chk($sformatf("t5_re%0d", k), bus_read_en, 0);
            @(negedge clk); #1;
        end
        w0 = wr_n; r0 = rd_n; h0 = halt_n;
        start_dma(8'h03);
        wait_done("t5", 1000);
        check_xfer("t5", w0, r0, h0, 8'h03, 8'h3C);
        readback("t5", 8'h3C);

        // Page FF, then back-to-back trigger on the first idle cycle
        w0 = wr_n; r0 = rd_n; h0 = halt_n;
        start_dma(8'hFF);
        wait_done("t6", 1000);
        core(OAMDMA_ADDR, 8'h02, 1'b1, 1'b0);
        #1 chk("t6_b2b_not_fwd", bus_write_en, 0);
        chk("t6_last_read", rd_log[rd_n - 1], 16'hFFFF);
        chk("t6_first_read", rd_log[r0], 16'hFF00);
        chk("t6_reads", rd_n - r0, 256);
        chk("t6_halt_cycles", halt_n - h0, 769);
        chk("t6_last_wr", wr_log[wr_n - 1], 8'h00);
        w0 = wr_n; r0 = rd_n; h0 = halt_n;
        @(negedge clk); core(16'h0000, 8'h00, 1'b0, 1'b0);
        #1 chk("t6_b2b_halt", core_halt, 1);
        wait_done("t6b", 1000);
        chk("t6b_writes", wr_n - w0, 256);
        chk("t6b_first_read", rd_log[r0], 16'h0200);
        chk("t6b_halt_cycles", halt_n - h0, 769);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
